// File: rtl/pcs_am_pkg.sv
// Shared 100GBASE-R alignment-marker definitions: lane marker table, AM sync header,
// lock FSM state type and the nominal marker period.
package pcs_am_pkg;

    localparam int N_LANES          = 20;
    localparam int NB_DATA_CODED    = 66;
    localparam int NB_AM            = 48;
    localparam int AM_PERIOD_BLOCKS = 16383;
    localparam int NB_LANE_ID       = $clog2(N_LANES);

    localparam logic [1:0] AM_SYNC_HEADER = 2'b10;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } am_state_e;

    // {M0,M1,M2,M4,M5,M6}; M4..M6 are the bitwise complements of M0..M2
    localparam logic [NB_AM-1:0] AM_TABLE [0:N_LANES-1] = '{
        48'hC16821_3E97DE, 48'h9D718E_628E71, 48'h594BE8_A6B417, 48'h4D957B_B26A84,
        48'hF50709_0AF8F6, 48'hDD14C2_22EB3D, 48'h9A4A26_65B5D9, 48'h7B4566_84BA99,
        48'hA02476_5FDB89, 48'h68C9FB_973604, 48'hFD6C99_029366, 48'hB99155_466EAA,
        48'h5CB9B2_A3464D, 48'h1AF8BD_E50742, 48'h83C7CA_7C3835, 48'h3536CD_CAC932,
        48'hC4314C_3BCEB3, 48'hADD6B7_522948, 48'h5F662A_A099D5, 48'hC0F0E5_3F0F1A
    };

    // BIP7 carries the complement of BIP3 on a well-formed marker
    function automatic logic bip_ok(input logic [7:0] bip3, input logic [7:0] bip7);
        return (bip7 == ~bip3);
    endfunction

endpackage

// File: rtl/lane_am_lock_if.sv
// Block stream bundle of one PCS lane: incoming blocks and the re-timed, tagged output.
interface lane_am_lock_if;
    import pcs_am_pkg::*;

    logic                     i_valid;
    logic [NB_DATA_CODED-1:0] i_data;
    logic [NB_DATA_CODED-1:0] o_data;
    logic                     o_valid;
    logic                     o_sol_tag;

    modport master (
        output i_valid, i_data,
        input  o_data, o_valid, o_sol_tag
    );

    modport slave (
        input  i_valid, i_data,
        output o_data, o_valid, o_sol_tag
    );

endinterface

// File: rtl/am_matcher.sv
// Combinational lane-marker compare: any-lane hit with lowest-ID priority, and
// match against one selected lane ID.
module am_matcher
    import pcs_am_pkg::*;
(
    input  logic [1:0]            i_header,
    input  logic [NB_AM-1:0]      i_am,
    input  logic [NB_LANE_ID-1:0] i_sel_id,
    output logic                  o_hit,
    output logic [NB_LANE_ID-1:0] o_hit_id,
    output logic                  o_sel_match
);

    logic [N_LANES-1:0] match_vec_s;

    // Per-lane pattern equality, qualified by the marker sync header
    always_comb begin
        match_vec_s = {N_LANES{1'b0}};
        for (int k = 0; k < N_LANES; k++) begin
            match_vec_s[k] = (i_header == AM_SYNC_HEADER) && (i_am == AM_TABLE[k]);
        end
    end

    // Priority encode (downward scan so the lowest ID wins) and selected-ID match
    always_comb begin
        o_hit       = |match_vec_s;
        o_hit_id    = {NB_LANE_ID{1'b0}};
        o_sel_match = 1'b0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            o_hit_id = match_vec_s[k] ? NB_LANE_ID'(k) : o_hit_id;
        end
        for (int k = 0; k < N_LANES; k++) begin
            o_sel_match = o_sel_match | (match_vec_s[k] & (i_sel_id == NB_LANE_ID'(k)));
        end
    end

endmodule

// File: rtl/lane_am_lock.sv
// Per-lane alignment-marker lock: search, period confirm, locked hysteresis, SOL tagging
// and read-clear counters. BIP field checking is built only with LANE_AM_LOCK_BIP_CHECK_EN.
module lane_am_lock
    import pcs_am_pkg::*;
#(
    parameter int AM_PERIOD_BLOCKS  = pcs_am_pkg::AM_PERIOD_BLOCKS,
    parameter int NB_AM_PERIOD      = $clog2(AM_PERIOD_BLOCKS + 1),
    parameter int NB_VAL_AM         = 5,
    parameter int NB_INV_AM         = 3,
    parameter int NB_ERROR_COUNTER  = 16,
    parameter int NB_RESYNC_COUNTER = 8
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    lane_am_lock_if.slave                blk,
    input  logic                         i_block_lock,
    input  logic                         i_enable,
    input  logic [NB_VAL_AM-1:0]         i_rf_valid_am_thr,
    input  logic [NB_INV_AM-1:0]         i_rf_invalid_am_thr,
    input  logic                         i_rf_read_counters,
    output logic                         o_am_lock,
    output logic [NB_LANE_ID-1:0]        o_lane_id,
    output logic [NB_ERROR_COUNTER-1:0]  o_rf_error_counter,
    output logic [NB_RESYNC_COUNTER-1:0] o_rf_resync_counter,
    output logic [NB_ERROR_COUNTER-1:0]  o_rf_bip_error_counter
);

    am_state_e                    state_r;
    logic [NB_AM_PERIOD-1:0]      period_cnt_r;
    logic [NB_VAL_AM-1:0]         good_cnt_r;
    logic [NB_INV_AM-1:0]         bad_cnt_r;
    logic [NB_ERROR_COUNTER-1:0]  err_cnt_r;
    logic [NB_RESYNC_COUNTER-1:0] resync_cnt_r;

    logic                         active_s;
    logic                         slot_s;
    logic                         hit_s;
    logic [NB_LANE_ID-1:0]        hit_id_s;
    logic                         sel_match_s;
    logic [NB_VAL_AM-1:0]         val_thr_s;
    logic [NB_INV_AM-1:0]         inv_thr_s;
    logic [NB_VAL_AM-1:0]         good_next_s;
    logic [NB_INV_AM-1:0]         bad_next_s;
    logic [NB_AM_PERIOD-1:0]      period_next_s;
    logic                         locked_slot_s;
    logic                         err_inc_s;
    logic                         resync_inc_s;
    logic [NB_ERROR_COUNTER-1:0]  err_next_s;
    logic [NB_RESYNC_COUNTER-1:0] resync_next_s;

    function automatic logic [NB_ERROR_COUNTER-1:0] sat_inc_err(input logic [NB_ERROR_COUNTER-1:0] v);
        return (&v) ? v : v + NB_ERROR_COUNTER'(1);
    endfunction

    function automatic logic [NB_RESYNC_COUNTER-1:0] sat_inc_rsy(input logic [NB_RESYNC_COUNTER-1:0] v);
        return (&v) ? v : v + NB_RESYNC_COUNTER'(1);
    endfunction

    am_matcher u_matcher (
        .i_header    (blk.i_data[65:64]),
        .i_am        ({blk.i_data[63:40], blk.i_data[31:8]}),
        .i_sel_id    (o_lane_id),
        .o_hit       (hit_s),
        .o_hit_id    (hit_id_s),
        .o_sel_match (sel_match_s)
    );

    assign active_s      = blk.i_valid & i_enable;
    assign slot_s        = (period_cnt_r == NB_AM_PERIOD'(AM_PERIOD_BLOCKS));
    assign period_next_s = slot_s ? {NB_AM_PERIOD{1'b0}} : period_cnt_r + NB_AM_PERIOD'(1);
    assign val_thr_s     = (i_rf_valid_am_thr == {NB_VAL_AM{1'b0}}) ? NB_VAL_AM'(1) : i_rf_valid_am_thr;
    assign inv_thr_s     = (i_rf_invalid_am_thr == {NB_INV_AM{1'b0}}) ? NB_INV_AM'(1) : i_rf_invalid_am_thr;
    assign good_next_s   = (&good_cnt_r) ? good_cnt_r : good_cnt_r + NB_VAL_AM'(1);
    assign bad_next_s    = (&bad_cnt_r) ? bad_cnt_r : bad_cnt_r + NB_INV_AM'(1);
    assign locked_slot_s = active_s & i_block_lock & (state_r == ST_LOCKED) & slot_s;
    assign err_inc_s     = locked_slot_s & ~sel_match_s;
    assign resync_inc_s  = err_inc_s & (bad_next_s >= inv_thr_s);

    // Lock FSM with registered lock flag and lane ID
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r      <= ST_SEARCH;
            period_cnt_r <= {NB_AM_PERIOD{1'b0}};
            good_cnt_r   <= {NB_VAL_AM{1'b0}};
            bad_cnt_r    <= {NB_INV_AM{1'b0}};
            o_am_lock    <= 1'b0;
            o_lane_id    <= {NB_LANE_ID{1'b0}};
        end else if (!i_block_lock) begin
            state_r      <= ST_SEARCH;
            period_cnt_r <= {NB_AM_PERIOD{1'b0}};
            good_cnt_r   <= {NB_VAL_AM{1'b0}};
            bad_cnt_r    <= {NB_INV_AM{1'b0}};
            o_am_lock    <= 1'b0;
        end else if (active_s) begin
            case (state_r)
                ST_SEARCH: begin
                    if (hit_s) begin
                        o_lane_id    <= hit_id_s;
                        period_cnt_r <= {NB_AM_PERIOD{1'b0}};
                        good_cnt_r   <= NB_VAL_AM'(1);
                        state_r      <= ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    period_cnt_r <= period_next_s;
                    if (slot_s && sel_match_s) begin
                        good_cnt_r <= good_next_s;
                        if (good_next_s >= val_thr_s) begin
                            state_r   <= ST_LOCKED;
                            o_am_lock <= 1'b1;
                            bad_cnt_r <= {NB_INV_AM{1'b0}};
                        end
                    end else if (slot_s) begin
                        state_r    <= ST_SEARCH;
                        good_cnt_r <= {NB_VAL_AM{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    period_cnt_r <= period_next_s;
                    if (resync_inc_s) begin
                        state_r    <= ST_SEARCH;
                        o_am_lock  <= 1'b0;
                        good_cnt_r <= {NB_VAL_AM{1'b0}};
                        bad_cnt_r  <= {NB_INV_AM{1'b0}};
                    end else if (err_inc_s) begin
                        bad_cnt_r <= bad_next_s;
                    end else if (slot_s) begin
                        bad_cnt_r <= {NB_INV_AM{1'b0}};
                    end
                end
                default: begin
                    state_r   <= ST_SEARCH;
                    o_am_lock <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle retiming of the block stream and the start-of-lane tag
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            blk.o_data    <= {NB_DATA_CODED{1'b0}};
            blk.o_valid   <= 1'b0;
            blk.o_sol_tag <= 1'b0;
        end else begin
            blk.o_data    <= blk.i_data;
            blk.o_valid   <= blk.i_valid;
            blk.o_sol_tag <= locked_slot_s;
        end
    end

    // A read clears the counter first, so a same-cycle increment lands as 1
    always_comb begin
        err_next_s    = i_rf_read_counters ? {NB_ERROR_COUNTER{1'b0}} : err_cnt_r;
        resync_next_s = i_rf_read_counters ? {NB_RESYNC_COUNTER{1'b0}} : resync_cnt_r;
        if (err_inc_s) begin
            err_next_s = sat_inc_err(err_next_s);
        end else begin
            err_next_s = err_next_s;
        end
        if (resync_inc_s) begin
            resync_next_s = sat_inc_rsy(resync_next_s);
        end else begin
            resync_next_s = resync_next_s;
        end
    end

    // Internal counters and their read snapshots
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            err_cnt_r           <= {NB_ERROR_COUNTER{1'b0}};
            resync_cnt_r        <= {NB_RESYNC_COUNTER{1'b0}};
            o_rf_error_counter  <= {NB_ERROR_COUNTER{1'b0}};
            o_rf_resync_counter <= {NB_RESYNC_COUNTER{1'b0}};
        end else begin
            err_cnt_r    <= err_next_s;
            resync_cnt_r <= resync_next_s;
            if (i_rf_read_counters) begin
                o_rf_error_counter  <= err_cnt_r;
                o_rf_resync_counter <= resync_cnt_r;
            end
        end
    end

`ifdef LANE_AM_LOCK_BIP_CHECK_EN
    logic [NB_ERROR_COUNTER-1:0] bip_cnt_r;
    logic [NB_ERROR_COUNTER-1:0] bip_next_s;
    logic                        bip_inc_s;

    assign bip_inc_s = locked_slot_s & ~bip_ok(blk.i_data[39:32], blk.i_data[7:0]);

    // BIP error count follows the same read-clear rule as the marker error count
    always_comb begin
        bip_next_s = i_rf_read_counters ? {NB_ERROR_COUNTER{1'b0}} : bip_cnt_r;
        if (bip_inc_s) begin
            bip_next_s = sat_inc_err(bip_next_s);
        end else begin
            bip_next_s = bip_next_s;
        end
    end

    // BIP counter and snapshot
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            bip_cnt_r              <= {NB_ERROR_COUNTER{1'b0}};
            o_rf_bip_error_counter <= {NB_ERROR_COUNTER{1'b0}};
        end else begin
            bip_cnt_r <= bip_next_s;
            if (i_rf_read_counters) begin
                o_rf_bip_error_counter <= bip_cnt_r;
            end
        end
    end
`else
    assign o_rf_bip_error_counter = {NB_ERROR_COUNTER{1'b0}};
`endif

endmodule

// File: tb/tb_lane_am_lock.sv
// Scoreboard bench for lane_am_lock with a 16-block marker period (15 data blocks between markers).
module tb_lane_am_lock;

    typedef struct packed {
        logic [65:0] data;
        logic        tag;
        logic        lock;
        logic [4:0]  id;
    } exp_t;

    typedef struct {
        string       name;
        logic [65:0] act;
        logic [65:0] exp;
    } dchk_t;

`ifdef LANE_AM_LOCK_BIP_CHECK_EN
    localparam int EXP_BIP = 4;
`else
    localparam int EXP_BIP = 0;
`endif

    localparam logic [23:0] M_LANE5  = 24'hDD14C2;
    localparam logic [23:0] M_LANE12 = 24'h5CB9B2;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_block_lock = 1'b1;
    logic        i_enable = 1'b1;
    logic [4:0]  i_rf_valid_am_thr = 5'd2;
    logic [2:0]  i_rf_invalid_am_thr = 3'd3;
    logic        i_rf_read_counters = 1'b0;
    logic        o_am_lock;
    logic [4:0]  o_lane_id;
    logic [15:0] o_rf_error_counter;
    logic [7:0]  o_rf_resync_counter;
    logic [15:0] o_rf_bip_error_counter;

    exp_t  exp_q[$];
    dchk_t dq[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    fill_n = 0;

    lane_am_lock_if bus ();

    lane_am_lock #(.AM_PERIOD_BLOCKS(15)) dut (
        .i_clock                (i_clock),
        .i_reset                (i_reset),
        .blk                    (bus),
        .i_block_lock           (i_block_lock),
        .i_enable               (i_enable),
        .i_rf_valid_am_thr      (i_rf_valid_am_thr),
        .i_rf_invalid_am_thr    (i_rf_invalid_am_thr),
        .i_rf_read_counters     (i_rf_read_counters),
        .o_am_lock              (o_am_lock),
        .o_lane_id              (o_lane_id),
        .o_rf_error_counter     (o_rf_error_counter),
        .o_rf_resync_counter    (o_rf_resync_counter),
        .o_rf_bip_error_counter (o_rf_bip_error_counter)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [65:0] mk_am(input logic [23:0] m, input logic bad_bip);
        logic [7:0] bip3;
        bip3 = 8'h3C;
        return {2'b10, m, bip3, ~m, (bad_bip ? bip3 : ~bip3)};
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected block whenever the DUT presents one, then drains direct checks
    always @(negedge i_clock) begin
        exp_t e;
        dchk_t d;
        if (i_reset && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_block", bus.o_data, 66'd0);
            end else begin
                e = exp_q.pop_front();
                chk("o_data", bus.o_data, e.data);
                chk("o_sol_tag", 66'(bus.o_sol_tag), 66'(e.tag));
                chk("o_am_lock", 66'(o_am_lock), 66'(e.lock));
                chk("o_lane_id", 66'(o_lane_id), 66'(e.id));
            end
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            chk(d.name, d.act, d.exp);
        end
    end

    task automatic post(input string name, input logic [65:0] act, input logic [65:0] exp);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dq.push_back(d);
    endtask

    task automatic send(input logic [65:0] d, input logic tag, input logic lock, input logic [4:0] id,
                        input logic en = 1'b1, input logic bl = 1'b1);
        exp_t e;
        @(negedge i_clock);
        bus.i_valid  = 1'b1;
        bus.i_data   = d;
        i_enable     = en;
        i_block_lock = bl;
        e.data = d;
        e.tag  = tag;
        e.lock = lock;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic fill(input int n, input logic lock, input logic [4:0] id);
        for (int i = 0; i < n; i++) begin
            fill_n++;
            send({2'b01, 32'hA5A5_0000, 32'(fill_n)}, 1'b0, lock, id);
        end
    endtask

    task automatic idle();
        @(negedge i_clock);
        bus.i_valid  = 1'b0;
        i_enable     = 1'b1;
        i_block_lock = 1'b1;
    endtask

    task automatic read_check(input int err, input int rsy, input int bip);
        idle();
        i_rf_read_counters = 1'b1;
        @(negedge i_clock);
        i_rf_read_counters = 1'b0;
        post("error_counter", 66'(o_rf_error_counter), 66'(err));
        post("resync_counter", 66'(o_rf_resync_counter), 66'(rsy));
        post("bip_counter", 66'(o_rf_bip_error_counter), 66'(bip));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = 66'd0;
        repeat (3) @(negedge i_clock);
        post("reset_o_valid", 66'(bus.o_valid), 66'd0);
        post("reset_o_am_lock", 66'(o_am_lock), 66'd0);
        post("reset_o_lane_id", 66'(o_lane_id), 66'd0);
        post("reset_o_sol_tag", 66'(bus.o_sol_tag), 66'd0);
        post("reset_o_data", bus.o_data, 66'd0);
        i_reset = 1'b1;

        // Acquire lane 5: lock after the second correctly spaced marker
        send(mk_am(M_LANE5, 1'b0), 1'b0, 1'b0, 5'd5);
        fill(15, 1'b0, 5'd5);
        send(mk_am(M_LANE5, 1'b0), 1'b0, 1'b1, 5'd5);
        fill(15, 1'b1, 5'd5);
        send(mk_am(M_LANE5, 1'b0), 1'b1, 1'b1, 5'd5);
        fill(12, 1'b1, 5'd5);
        // Disabled blocks pass through untagged and do not advance the period
        for (int i = 0; i < 3; i++) send({2'b01, 64'hDEAD_BEEF_0000_0000 | 64'(i)}, 1'b0, 1'b1, 5'd5, 1'b0);
        fill(3, 1'b1, 5'd5);

        // Two bad markers then a good one: lock held
        send(mk_am(M_LANE5 ^ 24'h800000, 1'b0), 1'b1, 1'b1, 5'd5);
        fill(15, 1'b1, 5'd5);
        send(mk_am(M_LANE5 ^ 24'h800000, 1'b0), 1'b1, 1'b1, 5'd5);
        fill(15, 1'b1, 5'd5);
        send(mk_am(M_LANE5, 1'b0), 1'b1, 1'b1, 5'd5);
        fill(15, 1'b1, 5'd5);
        read_check(2, 0, 0);

        // Three consecutive bad markers drop lock
        send(mk_am(M_LANE5 ^ 24'h800000, 1'b0), 1'b1, 1'b1, 5'd5);
        fill(15, 1'b1, 5'd5);
        send(mk_am(M_LANE5 ^ 24'h800000, 1'b0), 1'b1, 1'b1, 5'd5);
        fill(15, 1'b1, 5'd5);
        send(mk_am(M_LANE5 ^ 24'h800000, 1'b0), 1'b1, 1'b0, 5'd5);
        fill(15, 1'b0, 5'd5);
        read_check(3, 1, 0);
        send(mk_am(M_LANE5, 1'b0), 1'b0, 1'b0, 5'd5);
        fill(15, 1'b0, 5'd5);
        send(mk_am(M_LANE5, 1'b0), 1'b0, 1'b1, 5'd5);
        fill(15, 1'b1, 5'd5);

        // BIP-corrupted markers never affect lock
        for (int i = 0; i < 4; i++) begin
            send(mk_am(M_LANE5, 1'b1), 1'b1, 1'b1, 5'd5);
            fill(15, 1'b1, 5'd5);
        end
        read_check(0, 0, EXP_BIP);

        // Block lock loss: immediate drop, no resync count, relock
        send({2'b01, 64'h0123_4567_89AB_CDEF}, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        fill(3, 1'b0, 5'd5);
        read_check(0, 0, 0);
        send(mk_am(M_LANE5, 1'b0), 1'b0, 1'b0, 5'd5);
        fill(15, 1'b0, 5'd5);
        send(mk_am(M_LANE5, 1'b0), 1'b0, 1'b1, 5'd5);
        fill(15, 1'b1, 5'd5);

        // Lane 12, second marker one block late: confirm restarts from the late marker
        send({2'b01, 64'h0123_4567_89AB_CDEF}, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        send(mk_am(M_LANE12, 1'b0), 1'b0, 1'b0, 5'd12);
        fill(16, 1'b0, 5'd12);
        send(mk_am(M_LANE12, 1'b0), 1'b0, 1'b0, 5'd12);
        fill(15, 1'b0, 5'd12);
        send(mk_am(M_LANE12, 1'b0), 1'b0, 1'b1, 5'd12);
        fill(15, 1'b1, 5'd12);
        send(mk_am(M_LANE12, 1'b0), 1'b1, 1'b1, 5'd12);
        fill(15, 1'b1, 5'd12);
        // A different lane's marker while locked is a mismatch; ID stays 12
        send(mk_am(M_LANE5, 1'b0), 1'b1, 1'b1, 5'd12);
        fill(15, 1'b1, 5'd12);
        read_check(1, 0, 0);

        // Mid-operation reset discards the pending error count and lock
        send(mk_am(M_LANE12 ^ 24'h800000, 1'b0), 1'b1, 1'b1, 5'd12);
        idle();
        idle();
        i_reset = 1'b0;
        @(negedge i_clock);
        post("midreset_o_am_lock", 66'(o_am_lock), 66'd0);
        post("midreset_o_lane_id", 66'(o_lane_id), 66'd0);
        i_reset = 1'b1;
        read_check(0, 0, 0);

        idle();
        idle();
        post("scoreboard_empty", 66'(exp_q.size()), 66'd0);
        repeat (3) @(negedge i_clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
